spart_fifo: RTL and testbench

Buffered, parametrised SPART (serial port) core for the FPGA UART bring-up designs. It replaces the unbuffered SPART next to the driver in `top_level` and keeps the same processor-side bus (`iocs`/`iorw`/`ioaddr`/`databus`). It adds TX and RX FIFOs of configurable depth, a configurable data length, sticky error flags and a status register. It runs at 100 MHz with 16x oversampling and a programmable baud divisor.

---
 rtl/spart_fifo_if.sv | 14 +
 rtl/spart_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_spart_fifo.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_fifo_if.sv
// Processor-side control strobes and serial pins of the buffered SPART.
// The bidirectional databus stays a plain inout on the core.
interface spart_fifo_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       rxd;

  modport master (output iocs, iorw, ioaddr, rxd, input rda, tbr, txd);
  modport slave  (input iocs, iorw, ioaddr, rxd, output rda, tbr, txd);
endinterface

// File: rtl/spart_fifo.sv
// Buffered SPART: TX/RX FIFOs, programmable baud divisor, 16x oversampling, sticky errors.
// Define SPART_PARITY_EN to add an even-parity bit to every frame.
module spart_fifo #(
  parameter int          DATA_BITS = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd650
) (
  input  logic        clk,
  input  logic        rst,
  spart_fifo_if.slave bus,
  inout  wire  [7:0]  databus
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [2:0] BCNT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`ifdef SPART_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  logic w_rd, w_wr, w_div_wr, w_stat_clr, w_tick;
  logic [15:0] r_div, r_baud, w_div_new;
  logic [7:0] w_rdata, w_rx_head_ext;

  assign w_rd       = bus.iocs & bus.iorw;
  assign w_wr       = bus.iocs & ~bus.iorw;
  assign w_div_wr   = w_wr & bus.ioaddr[1];
  assign w_stat_clr = w_rd & (bus.ioaddr == 2'd1);
  assign w_tick     = (r_baud == 16'd0);

  always_comb begin
    w_div_new = r_div;
    if (bus.ioaddr[0]) w_div_new[15:8] = databus;
    else               w_div_new[7:0]  = databus;
  end

  // Baud generator: a divisor write restarts the count so the new rate applies at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= DIV_RESET;
      r_baud <= DIV_RESET;
    end else if (w_div_wr) begin
      r_div  <= w_div_new;
      r_baud <= w_div_new;
    end else if (w_tick) begin
      r_baud <= r_div;
    end else begin
      r_baud <= r_baud - 16'd1;
    end
  end

  // TX FIFO: a push onto a full FIFO is accepted when the FSM pops on the same edge.
  logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
  logic [TAW:0]         r_tx_wp, r_tx_rp;
  logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[TAW] != r_tx_rp[TAW]) && (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
  assign w_tx_push  = w_wr && (bus.ioaddr == 2'd0) && (!w_tx_full || w_tx_pop);
  assign w_tx_head  = r_tx_mem[r_tx_rp[TAW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= databus[DATA_BITS-1:0];
  end

  // TX FSM
  state_t               r_tx_state, w_tx_next;
  logic [3:0]           r_tx_tcnt;
  logic [2:0]           r_tx_bcnt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic                 r_txd, w_txd_nxt, w_tx_bit_done;
`ifdef SPART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_bit_done = w_tick && (r_tx_tcnt == 4'd15);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    unique case (r_tx_state)
      S_IDLE:   if (w_tick && !w_tx_empty) begin w_tx_next = S_START; w_tx_pop = 1'b1; end
      S_START:  if (w_tx_bit_done) w_tx_next = S_DATA;
      S_DATA:   if (w_tx_bit_done && r_tx_bcnt == BCNT_LAST) w_tx_next = AFTER_DATA;
      S_PARITY: if (w_tx_bit_done) w_tx_next = S_STOP;
      S_STOP:   if (w_tx_bit_done) begin
                  if (!w_tx_empty) begin w_tx_next = S_START; w_tx_pop = 1'b1; end
                  else w_tx_next = S_IDLE;
                end
      default:  w_tx_next = S_IDLE;
    endcase

    w_tx_shift_nxt = r_tx_shift;
    if (w_tx_pop) w_tx_shift_nxt = w_tx_head;
    else if (r_tx_state == S_DATA && w_tx_bit_done) w_tx_shift_nxt = r_tx_shift >> 1;

    unique case (w_tx_next)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_tx_shift_nxt[0];
`ifdef SPART_PARITY_EN
      S_PARITY: w_txd_nxt = r_tx_par;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_txd      <= w_txd_nxt;
      if (r_tx_state == S_IDLE) r_tx_tcnt <= '0;
      else if (w_tick)          r_tx_tcnt <= r_tx_tcnt + 4'd1;
      if (r_tx_state != S_DATA) r_tx_bcnt <= '0;
      else if (w_tx_bit_done)   r_tx_bcnt <= r_tx_bcnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift_nxt;
`ifdef SPART_PARITY_EN
    if (w_tx_pop) r_tx_par <= ^w_tx_head;
`endif
  end

  // RX: synchronised input, sampled at tick 8 of every bit period.
  state_t               r_rx_state, w_rx_next;
  logic                 r_rx_s1, r_rx_s2;
  logic [3:0]           r_rx_tcnt;
  logic [2:0]           r_rx_bcnt;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 w_rx_mid, w_rx_bit_done, w_rx_par_ok;
  logic                 w_rx_push_req, w_frame_bad, w_par_bad;
`ifdef SPART_PARITY_EN
  logic                 r_rx_parbit;
  assign w_rx_par_ok = ~^{r_rx_shift, r_rx_parbit};
`else
  assign w_rx_par_ok = 1'b1;
`endif

  assign w_rx_mid      = w_tick && (r_rx_tcnt == 4'd7);
  assign w_rx_bit_done = w_tick && (r_rx_tcnt == 4'd15);

  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_push_req = 1'b0;
    w_frame_bad   = 1'b0;
    w_par_bad     = 1'b0;
    unique case (r_rx_state)
      S_IDLE:   if (w_tick && !r_rx_s2) w_rx_next = S_START;
      S_START:  if (w_rx_mid && r_rx_s2) w_rx_next = S_IDLE;
                else if (w_rx_bit_done) w_rx_next = S_DATA;
      S_DATA:   if (w_rx_bit_done && r_rx_bcnt == BCNT_LAST) w_rx_next = AFTER_DATA;
      S_PARITY: if (w_rx_bit_done) w_rx_next = S_STOP;
      S_STOP:   if (w_rx_mid) begin
                  w_rx_next = S_IDLE;
                  if (!r_rx_s2)         w_frame_bad   = 1'b1;
                  else if (w_rx_par_ok) w_rx_push_req = 1'b1;
                  else                  w_par_bad     = 1'b1;
                end
      default:  w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
    end else begin
      r_rx_s1    <= bus.rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
      if (r_rx_state == S_IDLE) r_rx_tcnt <= '0;
      else if (w_tick)          r_rx_tcnt <= r_rx_tcnt + 4'd1;
      if (r_rx_state != S_DATA) r_rx_bcnt <= '0;
      else if (w_rx_bit_done)   r_rx_bcnt <= r_rx_bcnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_rx_state == S_DATA && w_rx_mid) r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
`ifdef SPART_PARITY_EN
    if (r_rx_state == S_PARITY && w_rx_mid) r_rx_parbit <= r_rx_s2;
`endif
  end

  // RX FIFO and sticky flags; a flag set beats a coincident status-read clear.
  logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
  logic [RAW:0]         r_rx_wp, r_rx_rp;
  logic                 w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_ovf_set;
  logic                 r_rx_ovf, r_frame_err, r_par_err, w_tx_idle;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) && (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);
  assign w_rx_pop   = w_rd && (bus.ioaddr == 2'd0) && !w_rx_empty;
  assign w_rx_push  = w_rx_push_req && (!w_rx_full || w_rx_pop);
  assign w_ovf_set  = w_rx_push_req && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wp     <= '0;
      r_rx_rp     <= '0;
      r_rx_ovf    <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_ovf    <= (r_rx_ovf    & ~w_stat_clr) | w_ovf_set;
      r_frame_err <= (r_frame_err & ~w_stat_clr) | w_frame_bad;
      r_par_err   <= (r_par_err   & ~w_stat_clr) | w_par_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= r_rx_shift;
  end

  assign w_tx_idle = w_tx_empty && (r_tx_state == S_IDLE);

  always_comb begin
    w_rx_head_ext = '0;
    w_rx_head_ext[DATA_BITS-1:0] = r_rx_mem[r_rx_rp[RAW-1:0]];
    unique case (bus.ioaddr)
      2'd0:    w_rdata = w_rx_empty ? 8'h00 : w_rx_head_ext;
      2'd1:    w_rdata = {2'b00, r_par_err, r_frame_err, r_rx_ovf, w_tx_idle, ~w_rx_empty, ~w_tx_full};
      2'd2:    w_rdata = r_div[7:0];
      default: w_rdata = r_div[15:8];
    endcase
  end

  assign databus = w_rd ? w_rdata : 8'hzz;
  assign bus.rda = ~w_rx_empty;
  assign bus.tbr = ~w_tx_full;
  assign bus.txd = r_txd;
endmodule

// File: tb/tb_spart_fifo.sv
// Directed bench for spart_fifo: register map, TX framing, FIFO fill, loopback, RX errors.
`timescale 1ns/1ps
module tb_spart_fifo;
  localparam int DB = 8;
`ifdef SPART_PARITY_EN
  localparam int FB = DB + 3;
`else
  localparam int FB = DB + 2;
`endif
  localparam int BIT_CYC = 64;
  localparam int FRAME_CYC = FB * BIT_CYC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spart_fifo_if bus();
  wire  [7:0] databus;
  logic [7:0] r_drv;
  logic       r_drv_en;
  logic       loop;
  logic       rxd_drv;
  assign databus = r_drv_en ? r_drv : 8'hzz;
  assign bus.rxd = loop ? bus.txd : rxd_drv;

  spart_fifo dut (.clk(clk), .rst(rst), .bus(bus), .databus(databus));

  int n_total = 0;
  int n_bad = 0;

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; r_drv = d; r_drv_en = 1'b1;
    @(posedge clk); #1;
    bus.iocs = 1'b0; r_drv_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #2 d = databus;
    @(posedge clk); #1;
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (BIT_CYC) @(posedge clk); #1;
    for (int i = 0; i < DB; i++) begin
      rxd_drv = d[i];
      repeat (BIT_CYC) @(posedge clk); #1;
    end
`ifdef SPART_PARITY_EN
    rxd_drv = ^d;
    repeat (BIT_CYC) @(posedge clk); #1;
`endif
    rxd_drv = stop;
    repeat (BIT_CYC) @(posedge clk); #1;
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (bus.txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", bus.txd); end
    n_total++; if (bus.rda !== 1'b0) begin n_bad++; $display("FAIL reset_rda: got %b want 0", bus.rda); end
    n_total++; if (bus.tbr !== 1'b1) begin n_bad++; $display("FAIL reset_tbr: got %b want 1", bus.tbr); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h05) begin n_bad++; $display("FAIL reset_status: got %h want 05", d); end
    cpu_read(2'd2, d);
    n_total++; if (d !== 8'h8A) begin n_bad++; $display("FAIL reset_div_lo: got %h want 8a", d); end
    cpu_read(2'd3, d);
    n_total++; if (d !== 8'h02) begin n_bad++; $display("FAIL reset_div_hi: got %h want 02", d); end
    cpu_read(2'd0, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_empty_rd: got %h want 00", d); end
    // with iocs low the core must leave the bus alone, so the bench's own drive shows through
    @(posedge clk); #1;
    bus.iorw = 1'b1; r_drv = 8'hA5; r_drv_en = 1'b1;
    #2;
    n_total++; if (databus !== 8'hA5) begin n_bad++; $display("FAIL bus_release: got %h want a5", databus); end
    r_drv_en = 1'b0; bus.iorw = 1'b0;
  endtask

  task automatic test_divisor;
    logic [7:0] d;
    cpu_write(2'd2, 8'h03);
    cpu_write(2'd3, 8'h00);
    cpu_read(2'd2, d);
    n_total++; if (d !== 8'h03) begin n_bad++; $display("FAIL div_lo: got %h want 03", d); end
    cpu_read(2'd3, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL div_hi: got %h want 00", d); end
  endtask

  task automatic test_tx_pattern;
    logic [7:0]  d;
    logic [10:0] exp_bits;
    int n;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) exp_bits[i+1] = (i % 2 == 0);
`ifdef SPART_PARITY_EN
    exp_bits[DB+1] = 1'b0;
`endif
    cpu_write(2'd0, 8'h55);
    n = 0;
    while (bus.txd !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    n_total++; if (n >= 20) begin n_bad++; $display("FAIL tx_start_timeout: waited %0d cycles want <20", n); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h01) begin n_bad++; $display("FAIL tx_busy_status: got %h want 01", d); end
    repeat (30) @(posedge clk); #1;
    for (int i = 0; i < FB; i++) begin
      if (i > 0) begin repeat (BIT_CYC) @(posedge clk); #1; end
      n_total++;
      if (bus.txd !== exp_bits[i]) begin n_bad++; $display("FAIL tx_bit%0d: got %b want %b", i, bus.txd, exp_bits[i]); end
    end
    repeat (48) @(posedge clk); #1;
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h05) begin n_bad++; $display("FAIL tx_idle_after: got %h want 05", d); end
  endtask

  task automatic test_tx_fill;
    logic [7:0] d;
    int t0, el, polls;
    for (int i = 0; i < 9; i++) begin
      cpu_write(2'd0, 8'h30 + 8'(i));
      if (i == 0) t0 = cyc;
      if (i == 7) begin
        n_total++; if (bus.tbr !== 1'b1) begin n_bad++; $display("FAIL fill_tbr8: got %b want 1", bus.tbr); end
      end
    end
    n_total++; if (bus.tbr !== 1'b0) begin n_bad++; $display("FAIL fill_tbr9: got %b want 0", bus.tbr); end
    cpu_write(2'd0, 8'hEE);
    n_total++; if (bus.tbr !== 1'b0) begin n_bad++; $display("FAIL fill_tbr10: got %b want 0", bus.tbr); end
    d = 8'h00;
    polls = 0;
    while (d[2] !== 1'b1 && polls < 4000) begin cpu_read(2'd1, d); polls++; end
    el = cyc - t0;
    n_total++;
    if (el < 9 * FRAME_CYC || el > 9 * FRAME_CYC + 8) begin
      n_bad++; $display("FAIL fill_duration: got %0d cycles want %0d..%0d", el, 9 * FRAME_CYC, 9 * FRAME_CYC + 8);
    end
    n_total++; if (d !== 8'h05) begin n_bad++; $display("FAIL fill_final_status: got %h want 05", d); end
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    int n;
    loop = 1'b1;
    cpu_write(2'd0, 8'hA3);
    n = 0;
    while (bus.rda !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    n_total++; if (n >= 1000) begin n_bad++; $display("FAIL loop_rda_timeout: waited %0d cycles want <1000", n); end
    cpu_read(2'd0, d);
    n_total++; if (d !== 8'hA3) begin n_bad++; $display("FAIL loop_data: got %h want a3", d); end
    n_total++; if (bus.rda !== 1'b0) begin n_bad++; $display("FAIL loop_rda_clear: got %b want 0", bus.rda); end
    repeat (100) @(posedge clk); #1;
    loop = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1);
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h0F) begin n_bad++; $display("FAIL ovf_status: got %h want 0f", d); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h07) begin n_bad++; $display("FAIL ovf_cleared: got %h want 07", d); end
    for (int i = 0; i < 8; i++) begin
      cpu_read(2'd0, d);
      n_total++;
      if (d !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL ovf_data%0d: got %h want %h", i, d, 8'h10 + 8'(i)); end
    end
    n_total++; if (bus.rda !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", bus.rda); end
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    send_frame(8'h5A, 1'b0);
    repeat (200) @(posedge clk); #1;
    n_total++; if (bus.rda !== 1'b0) begin n_bad++; $display("FAIL ferr_no_push: got %b want 0", bus.rda); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h15) begin n_bad++; $display("FAIL ferr_status: got %h want 15", d); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h05) begin n_bad++; $display("FAIL ferr_cleared: got %h want 05", d); end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (12) @(posedge clk); #1;
    rxd_drv = 1'b1;
    repeat (FRAME_CYC + 64) @(posedge clk); #1;
    n_total++; if (bus.rda !== 1'b0) begin n_bad++; $display("FAIL glitch_no_push: got %b want 0", bus.rda); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h05) begin n_bad++; $display("FAIL glitch_status: got %h want 05", d); end
  endtask

`ifdef SPART_PARITY_EN
  task automatic test_parity;
    logic [7:0] d;
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (BIT_CYC) @(posedge clk); #1;
    for (int i = 0; i < DB; i++) begin
      rxd_drv = (i < 3);
      repeat (BIT_CYC) @(posedge clk); #1;
    end
    rxd_drv = 1'b0;
    repeat (BIT_CYC) @(posedge clk); #1;
    rxd_drv = 1'b1;
    repeat (BIT_CYC + 64) @(posedge clk); #1;
    n_total++; if (bus.rda !== 1'b0) begin n_bad++; $display("FAIL par_no_push: got %b want 0", bus.rda); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h25) begin n_bad++; $display("FAIL par_status: got %h want 25", d); end
  endtask
`endif

  task automatic test_reset_midframe;
    logic [7:0] d;
    int n;
    cpu_write(2'd0, 8'h0F);
    cpu_write(2'd0, 8'hF0);
    n = 0;
    while (bus.txd !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    n_total++; if (n >= 20) begin n_bad++; $display("FAIL mid_start_timeout: waited %0d cycles want <20", n); end
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.txd !== 1'b1) begin n_bad++; $display("FAIL mid_rst_txd: got %b want 1", bus.txd); end
    rst = 1'b0;
    repeat (700) @(posedge clk); #1;
    n_total++; if (bus.txd !== 1'b1) begin n_bad++; $display("FAIL mid_rst_quiet: got %b want 1", bus.txd); end
    cpu_read(2'd1, d);
    n_total++; if (d !== 8'h05) begin n_bad++; $display("FAIL mid_rst_status: got %h want 05", d); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'd0;
    r_drv = 8'h00; r_drv_en = 1'b0;
    loop = 1'b0; rxd_drv = 1'b1;
    test_reset;
    test_divisor;
    test_tx_pattern;
    test_tx_fill;
    test_loopback;
    test_overflow;
    test_frame_err;
    test_glitch;
`ifdef SPART_PARITY_EN
    test_parity;
`endif
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
